// File: rtl/pong_pkg.sv
// Shared Pong types and screen/paddle geometry used by ball motion,
// the renderer and the paddle logic.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        SCORED     = 2'd3
    } ball_state_t;

    typedef logic signed [11:0] coord_t;

    localparam coord_t H_ACTIVE   = 12'sd640;
    localparam coord_t V_ACTIVE   = 12'sd480;
    localparam coord_t BALL_SIZE  = 12'sd25;
    localparam coord_t BALL_INI_X = 12'sd269;
    localparam coord_t BALL_INI_Y = 12'sd189;
    localparam coord_t VEL        = 12'sd4;
    localparam coord_t VEL_MAX    = 12'sd12;
    localparam coord_t PADDLE_W   = 12'sd10;
    localparam coord_t PADDLE_H   = 12'sd150;
    localparam coord_t L_PADDLE_X = 12'sd40;
    localparam coord_t R_PADDLE_X = 12'sd600;

    localparam logic [5:0] SERVE_FRAMES = 6'd60;
    localparam logic [5:0] SERVE_LAST   = SERVE_FRAMES - 6'd1;

    // Derived limits for the ball's top-left corner.
    localparam coord_t Y_MAX   = V_ACTIVE - BALL_SIZE;
    localparam coord_t X_MISS  = H_ACTIVE - BALL_SIZE;
    localparam coord_t R_HIT_X = R_PADDLE_X - BALL_SIZE;
    localparam coord_t L_HIT_X = L_PADDLE_X + PADDLE_W;

    function automatic coord_t abs_c(input coord_t v);
        abs_c = (v < 12'sd0) ? -v : v;
    endfunction

    function automatic coord_t sat_inc(input coord_t v, input coord_t lim);
        sat_inc = (v >= lim) ? lim : v + 12'sd1;
    endfunction

    // Magnitude mag with the sign of dir.
    function automatic coord_t signed_mag(input coord_t dir, input coord_t mag);
        signed_mag = (dir < 12'sd0) ? -mag : mag;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Frame/serve/paddle inputs and ball position/event outputs of ball_motion.
interface ball_motion_if;
    logic       frame_tick;
    logic       serve_req;
    logic [9:0] paddle_L_y;
    logic [9:0] paddle_R_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_play;
    logic       score_L;
    logic       score_R;
    logic       hit_wall;
    logic       hit_paddle;

    modport master (
        output frame_tick, serve_req, paddle_L_y, paddle_R_y,
        input  ball_x, ball_y, in_play, score_L, score_R, hit_wall, hit_paddle
    );

    modport slave (
        input  frame_tick, serve_req, paddle_L_y, paddle_R_y,
        output ball_x, ball_y, in_play, score_L, score_R, hit_wall, hit_paddle
    );
endinterface

// File: rtl/ball_motion_aabb_overlap.sv
// 1-D span overlap: [a_pos, a_pos+a_len) intersects [b_pos, b_pos+b_len).
module aabb_overlap
    import pong_pkg::*;
(
    input  coord_t a_pos,
    input  coord_t a_len,
    input  coord_t b_pos,
    input  coord_t b_len,
    output logic   overlap
);
    assign overlap = ((a_pos + a_len) > b_pos) && (a_pos < (b_pos + b_len));
endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity per video frame: serve countdown, wall and paddle
// bounces, miss detection. Optional paddle speed-up under BALL_SPEEDUP_EN.
module ball_motion
    import pong_pkg::*;
(
    input  logic         pixel_clk,
    input  logic         reset,
    ball_motion_if.slave bus
);

    ball_state_t state_r, state_s;
    coord_t      x_r, y_r, vx_r, vy_r;
    coord_t      x_s, y_s, vx_s, vy_s;
    coord_t      nx_s, ny_s, y_wall_s, vy_wall_s, pad_l_s, pad_r_s, mag_s;
    logic [5:0]  cnt_r, cnt_s;
    logic        wall_s, ovl_l_s, ovl_r_s, hit_l_s, hit_r_s;
    logic        wall_pulse_s, paddle_s, score_l_s, score_r_s;
    logic        in_play_r, score_l_r, score_r_r, hit_wall_r, hit_paddle_r;

    assign nx_s    = x_r + vx_r;
    assign ny_s    = y_r + vy_r;
    assign pad_l_s = {2'b00, bus.paddle_L_y};
    assign pad_r_s = {2'b00, bus.paddle_R_y};

    // Top/bottom wall clamp and reflection of the candidate position.
    always_comb begin
        y_wall_s  = ny_s;
        vy_wall_s = vy_r;
        wall_s    = 1'b0;
        if (ny_s <= 12'sd0) begin
            y_wall_s  = 12'sd0;
            vy_wall_s = abs_c(vy_r);
            wall_s    = 1'b1;
        end else if (ny_s >= Y_MAX) begin
            y_wall_s  = Y_MAX;
            vy_wall_s = -abs_c(vy_r);
            wall_s    = 1'b1;
        end else begin
            y_wall_s  = ny_s;
            vy_wall_s = vy_r;
            wall_s    = 1'b0;
        end
    end

    // Paddle overlap uses the post-clamp y so corner hits on a wall frame count.
    aabb_overlap u_ovl_l (
        .a_pos   (y_wall_s),
        .a_len   (BALL_SIZE),
        .b_pos   (pad_l_s),
        .b_len   (PADDLE_H),
        .overlap (ovl_l_s)
    );

    aabb_overlap u_ovl_r (
        .a_pos   (y_wall_s),
        .a_len   (BALL_SIZE),
        .b_pos   (pad_r_s),
        .b_len   (PADDLE_H),
        .overlap (ovl_r_s)
    );

    assign hit_r_s = (vx_r > 12'sd0) && (x_r < R_HIT_X) && (nx_s >= R_HIT_X) && ovl_r_s;
    assign hit_l_s = (vx_r < 12'sd0) && (x_r > L_HIT_X) && (nx_s <= L_HIT_X) && ovl_l_s;

`ifdef BALL_SPEEDUP_EN
    coord_t speed_r;

    assign mag_s = sat_inc(speed_r, VEL_MAX);

    // Current per-axis speed; bumps on each paddle hit, restarts on a new rally.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            speed_r <= VEL;
        end else if (state_r == SCORED) begin
            speed_r <= VEL;
        end else if (paddle_s) begin
            speed_r <= mag_s;
        end else begin
            speed_r <= speed_r;
        end
    end
`else
    assign mag_s = abs_c(vx_r);
`endif

    // Next-state and per-frame kinematics.
    always_comb begin
        state_s      = state_r;
        x_s          = x_r;
        y_s          = y_r;
        vx_s         = vx_r;
        vy_s         = vy_r;
        cnt_s        = cnt_r;
        wall_pulse_s = 1'b0;
        paddle_s     = 1'b0;
        score_l_s    = 1'b0;
        score_r_s    = 1'b0;
        case (state_r)
            IDLE: begin
                x_s = BALL_INI_X;
                y_s = BALL_INI_Y;
                if (bus.serve_req) begin
                    state_s = SERVE_WAIT;
                    cnt_s   = 6'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_WAIT: begin
                if (bus.frame_tick) begin
                    if (cnt_r == SERVE_LAST) begin
                        state_s = PLAY;
                        cnt_s   = 6'd0;
                    end else begin
                        cnt_s = cnt_r + 6'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    y_s          = y_wall_s;
                    vy_s         = vy_wall_s;
                    wall_pulse_s = wall_s;
                    x_s          = nx_s;
                    if (hit_r_s) begin
                        x_s      = R_HIT_X;
                        vx_s     = -mag_s;
                        paddle_s = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        vy_s     = signed_mag(vy_wall_s, mag_s);
`endif
                    end else if (hit_l_s) begin
                        x_s      = L_HIT_X;
                        vx_s     = mag_s;
                        paddle_s = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        vy_s     = signed_mag(vy_wall_s, mag_s);
`endif
                    end else begin
                        x_s = nx_s;
                    end
                    // The exit frame leaves the ball where it was last drawn.
                    if (x_s >= X_MISS) begin
                        score_l_s = 1'b1;
                        state_s   = SCORED;
                        x_s       = x_r;
                        y_s       = y_r;
                    end else if (x_s <= 12'sd0) begin
                        score_r_s = 1'b1;
                        state_s   = SCORED;
                        x_s       = x_r;
                        y_s       = y_r;
                    end else begin
                        state_s = PLAY;
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            SCORED: begin
                // Serve toward the player who just scored.
                x_s     = BALL_INI_X;
                y_s     = BALL_INI_Y;
                vx_s    = score_l_r ? -VEL : VEL;
                vy_s    = VEL;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, kinematics and registered event outputs.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_r      <= IDLE;
            x_r          <= BALL_INI_X;
            y_r          <= BALL_INI_Y;
            vx_r         <= VEL;
            vy_r         <= VEL;
            cnt_r        <= 6'd0;
            in_play_r    <= 1'b0;
            score_l_r    <= 1'b0;
            score_r_r    <= 1'b0;
            hit_wall_r   <= 1'b0;
            hit_paddle_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            x_r          <= x_s;
            y_r          <= y_s;
            vx_r         <= vx_s;
            vy_r         <= vy_s;
            cnt_r        <= cnt_s;
            in_play_r    <= (state_s == PLAY);
            score_l_r    <= score_l_s;
            score_r_r    <= score_r_s;
            hit_wall_r   <= wall_pulse_s;
            hit_paddle_r <= paddle_s;
        end
    end

    assign bus.ball_x     = x_r[9:0];
    assign bus.ball_y     = y_r[9:0];
    assign bus.in_play    = in_play_r;
    assign bus.score_L    = score_l_r;
    assign bus.score_R    = score_r_r;
    assign bus.hit_wall   = hit_wall_r;
    assign bus.hit_paddle = hit_paddle_r;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion (default build, fixed speed).
module tb_ball_motion;
    import pong_pkg::*;

    logic pixel_clk;
    logic reset;
    int   tests;
    int   fails;

    ball_motion_if bus ();

    ball_motion dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame_tick pulse; returns at the negedge after the update edge.
    task automatic frame();
        @(negedge pixel_clk) bus.frame_tick = 1'b1;
        @(negedge pixel_clk) bus.frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic serve();
        @(negedge pixel_clk) bus.serve_req = 1'b1;
        @(negedge pixel_clk) bus.serve_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge pixel_clk) reset = 1'b1;
        @(negedge pixel_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.serve_req  = 1'b0;
        bus.paddle_L_y = 10'd100;
        bus.paddle_R_y = 10'd300;
        repeat (3) @(negedge pixel_clk);
        reset = 1'b0;

        // Reset state
        chk("rst_x", bus.ball_x, 189 + 80);
        chk("rst_y", bus.ball_y, 189);
        chk("rst_in_play", bus.in_play, 0);
        chk("rst_pulses", {bus.score_L, bus.score_R, bus.hit_wall, bus.hit_paddle}, 0);
        chk("rst_vx", dut.vx_r, 4);
        chk("rst_vy", dut.vy_r, 4);
        chk("rst_state", dut.state_r, IDLE);

        // frame_tick in IDLE does nothing
        frame();
        chk("idle_tick_state", dut.state_r, IDLE);
        chk("idle_tick_x", bus.ball_x, 269);

        // Serve A: right paddle at 300, left at 100
        serve();
        chk("serve_state", dut.state_r, SERVE_WAIT);
        frames(59);
        chk("wait59_in_play", bus.in_play, 0);
        chk("wait59_x", bus.ball_x, 269);
        chk("wait59_y", bus.ball_y, 189);
        frame();
        chk("wait60_in_play", bus.in_play, 1);
        chk("wait60_x", bus.ball_x, 269);

        // serve_req held during play is ignored
        frames(19);
        bus.serve_req = 1'b1;
        frames(11);
        bus.serve_req = 1'b0;
        chk("t30_x", bus.ball_x, 389);
        chk("t30_y", bus.ball_y, 309);
        chk("t30_state", dut.state_r, PLAY);

        frames(36);
        chk("t66_y", bus.ball_y, 453);
        chk("t66_wall", bus.hit_wall, 0);
        frame();
        chk("t67_y", bus.ball_y, 455);
        chk("t67_x", bus.ball_x, 537);
        chk("t67_wall", bus.hit_wall, 1);
        chk("t67_vy", dut.vy_r, -4);
        @(negedge pixel_clk);
        chk("t67_wall_drop", bus.hit_wall, 0);

        frames(9);
        chk("t76_x", bus.ball_x, 573);
        chk("t76_y", bus.ball_y, 419);
        frame();
        chk("t77_x", bus.ball_x, 575);
        chk("t77_y", bus.ball_y, 415);
        chk("t77_hit_paddle", bus.hit_paddle, 1);
        chk("t77_vx", dut.vx_r, -4);
        frame();
        chk("t78_x", bus.ball_x, 571);
        chk("t78_y", bus.ball_y, 411);
        chk("t78_hit_paddle", bus.hit_paddle, 0);

        // Top wall: next_y = -1 clamps to 0
        frames(102);
        chk("t180_y", bus.ball_y, 3);
        frame();
        chk("t181_y", bus.ball_y, 0);
        chk("t181_x", bus.ball_x, 159);
        chk("t181_wall", bus.hit_wall, 1);
        chk("t181_vy", dut.vy_r, 4);

        // Left paddle: x=51 -> next_x=47 clamps to 50
        frames(27);
        chk("t208_x", bus.ball_x, 51);
        frame();
        chk("t209_x", bus.ball_x, 50);
        chk("t209_y", bus.ball_y, 112);
        chk("t209_hit_paddle", bus.hit_paddle, 1);
        chk("t209_vx", dut.vx_r, 4);

        pulse_reset();
        chk("rstA_state", dut.state_r, IDLE);
        chk("rstA_x", bus.ball_x, 269);
        chk("rstA_score", {bus.score_L, bus.score_R}, 0);
        reset = 1'b0;

        // Serve B: right paddle at 0 -> miss, left scores
        bus.paddle_R_y = 10'd0;
        serve();
        frames(60);
        chk("B_in_play", bus.in_play, 1);
        frames(76);
        frame();
        chk("B_t77_x", bus.ball_x, 577);
        chk("B_t77_hit_paddle", bus.hit_paddle, 0);
        frames(9);
        chk("B_t86_x", bus.ball_x, 613);
        chk("B_t86_y", bus.ball_y, 379);
        chk("B_t86_score", bus.score_L, 0);
        frame();
        chk("B_t87_score_L", bus.score_L, 1);
        chk("B_t87_score_R", bus.score_R, 0);
        chk("B_t87_x", bus.ball_x, 613);
        chk("B_t87_y", bus.ball_y, 379);
        chk("B_t87_in_play", bus.in_play, 0);
        chk("B_t87_state", dut.state_r, SCORED);
        @(negedge pixel_clk);
        chk("B_idle_state", dut.state_r, IDLE);
        chk("B_idle_x", bus.ball_x, 269);
        chk("B_idle_y", bus.ball_y, 189);
        chk("B_idle_vx", dut.vx_r, -4);
        chk("B_idle_vy", dut.vy_r, 4);
        chk("B_score_drop", bus.score_L, 0);

        // Serve C: heads left, reset at play tick 40
        serve();
        frames(60);
        frames(40);
        chk("C_t40_x", bus.ball_x, 109);
        chk("C_t40_y", bus.ball_y, 349);
        pulse_reset();
        chk("C_rst_state", dut.state_r, IDLE);
        chk("C_rst_x", bus.ball_x, 269);
        chk("C_rst_y", bus.ball_y, 189);
        chk("C_rst_score", {bus.score_L, bus.score_R}, 0);
        chk("C_rst_vx", dut.vx_r, 4);
        reset = 1'b0;
        frame();
        chk("C_idle_tick_state", dut.state_r, IDLE);
        chk("C_idle_tick_in_play", bus.in_play, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
